// File: rtl/button_event_decoder.sv
// Purpose : turns a debounced button level into one-cycle short / long / repeat / double-click pulses.
// Latency : every pulse is registered and appears one cycle after the edge that decides it.
// Backpressure: none; the events are fire-and-forget pulses and the consumer must take them as they come.
// Ports   : i_clk, i_rst (synchronous, active-high); i_in = debounced level, 1 = pressed;
//           o_short / o_long / o_repeat / o_double = mutually exclusive event pulses;
//           o_busy = high whenever the FSM is outside IDLE (combinational decode of the state).
module button_event_decoder #(
  parameter int p_long   = 50_000_000,
  parameter int p_gap    = 12_500_000,
  parameter int p_repeat = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_double,
  output logic o_busy
);

  // One counter is shared by every timed state, so it is sized for the largest interval.
  localparam int max_lg = (p_long > p_gap) ? p_long : p_gap;
  localparam int max_all = (max_lg > p_repeat) ? max_lg : p_repeat;
  localparam int cw = $clog2(max_all + 1);

  localparam logic [cw-1:0] long_last = cw'(p_long - 1);
  localparam logic [cw-1:0] gap_last = cw'(p_gap - 1);
  localparam logic [cw-1:0] rep_last = (p_repeat == 0) ? '0 : cw'(p_repeat - 1);
  localparam logic [cw-1:0] cnt_one = cw'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    WAIT2    = 3'd2,
    HELD     = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic [cw-1:0] l_count, count_nxt;
  logic short_nxt, long_nxt, repeat_nxt, double_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      l_count  <= '0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      o_double <= 1'b0;
    end else begin
      state    <= state_nxt;
      l_count  <= count_nxt;
      o_short  <= short_nxt;
      o_long   <= long_nxt;
      o_repeat <= repeat_nxt;
      o_double <= double_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = l_count;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (i_in) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (i_in && l_count == long_last) begin
          state_nxt = HELD;
          count_nxt = '0;
          long_nxt  = 1'b1;
        end else if (!i_in) begin
          state_nxt = WAIT2;
          count_nxt = '0;
        end else begin
          count_nxt = l_count + cnt_one;
        end
      end
      WAIT2: begin
        // A second press on the same edge as gap expiry still counts as a double click.
        if (i_in) begin
          state_nxt  = WAIT_REL;
          count_nxt  = '0;
          double_nxt = 1'b1;
        end else if (l_count == gap_last) begin
          state_nxt = IDLE;
          count_nxt = '0;
          short_nxt = 1'b1;
        end else begin
          count_nxt = l_count + cnt_one;
        end
      end
      HELD: begin
        if (!i_in) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (p_repeat != 0) begin
          if (l_count == rep_last) begin
            count_nxt  = '0;
            repeat_nxt = 1'b1;
          end else begin
            count_nxt = l_count + cnt_one;
          end
        end
      end
      WAIT_REL: begin
        // Second press of a double click: wait for release only, no long detection.
        count_nxt = '0;
        if (!i_in) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule
